// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch buffer
// Contents: INST_W, DEFAULT_RESET_PC, fetch_state_t (fetch FSM states),
//           fetch_entry_t (one prefetched {pc, inst} entry).
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,  // no request outstanding
    FETCH_WAIT    = 2'd1,  // request outstanding, data will be kept
    FETCH_DISCARD = 2'd2   // request outstanding, data will be dropped
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular FIFO holding prefetched {pc, inst} entries
// Ports: clk, rst_b (sync, active-low); push/push_data write the tail;
//        pop retires the head; flush empties the FIFO (wins over push/pop);
//        head is the oldest entry; count is the current entry count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_b || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - instruction prefetch buffer with redirect and halt
// Ports: clk, rst_b (sync, active-low);
//        imem_req/imem_addr/imem_ack/imem_rdata - instruction memory read port;
//        inst_valid/inst/inst_addr/inst_ready - head instruction toward the core;
//        redirect_valid/redirect_pc - taken branch, flush and refetch;
//        halted - stop issuing new fetches; occupancy - FIFO entry count.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst_b,
  output logic                       imem_req,
  output logic [INST_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_W-1:0]          imem_rdata,
  output logic                       inst_valid,
  output logic [INST_W-1:0]          inst,
  output logic [INST_W-1:0]          inst_addr,
  input  logic                       inst_ready,
  input  logic                       redirect_valid,
  input  logic [INST_W-1:0]          redirect_pc,
  input  logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [INST_W-1:0] fetch_pc;
  logic [INST_W-1:0] hold_addr;   // address of a request being discarded
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_after;
  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic              issue_idle;
  logic              ack_take;
  logic              push;
  logic              pop;
  logic              room;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    // From idle a request goes out in the same cycle the conditions hold.
    issue_idle  = (state == FETCH_IDLE) && !halted && !redirect_valid
                  && (count < CW'(DEPTH));
    // Gating with rst_b keeps the port quiet while reset is held.
    imem_req    = rst_b && ((state != FETCH_IDLE) || issue_idle);
    imem_addr   = (state == FETCH_DISCARD) ? hold_addr : fetch_pc;
    ack_take    = imem_req && imem_ack;
    push        = ack_take && (state != FETCH_DISCARD) && !redirect_valid;
    pop         = inst_valid && inst_ready && !redirect_valid;
    count_after = count + CW'(push) - CW'(pop);
    room        = count_after < CW'(DEPTH);
    push_data   = '{pc: fetch_pc, inst: imem_rdata};
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: begin
        if (issue_idle) begin
          if (imem_ack) state_next = room ? FETCH_WAIT : FETCH_IDLE;
          else          state_next = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (redirect_valid) begin
          // Data returning with the redirect is simply dropped.
          state_next = imem_ack ? FETCH_IDLE : FETCH_DISCARD;
        end else if (imem_ack) begin
          state_next = (room && !halted) ? FETCH_WAIT : FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        if (imem_ack) state_next = FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= FETCH_IDLE;
      fetch_pc  <= RESET_PC;
      hold_addr <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[INST_W-1:2], 2'b00};
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if ((state == FETCH_WAIT) && redirect_valid && !imem_ack) begin
        hold_addr <= fetch_pc;
      end
    end
  end

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_addr  = inst_valid ? head.pc   : '0;
  assign occupancy  = count;

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 Parameter DEPTH, 4, number of prefetched instruction entries (power of two, >=2).
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address; stable while imem_req high and no imem_ack.
REQ-007 imem_ack  input  1  read complete this cycle; sampled only while imem_req high.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-009 inst_valid  output  1  head entry valid toward core.
REQ-010 inst  output  32  head instruction word.
REQ-011 inst_addr  output  32  PC of head instruction.
REQ-012 inst_ready  input  1  core consumes head when inst_valid && inst_ready.
REQ-013 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-014 redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0.
REQ-015 halted  input  1  core halted; stop issuing new requests.
REQ-016 occupancy  output  $clog2(DEPTH+1)  current FIFO entry count.

Function
REQ-017 FIFO of DEPTH {pc, inst} entries; inst_valid = (count != 0); inst/inst_addr driven from head.
REQ-018 States FETCH_IDLE (no request outstanding), FETCH_WAIT (request outstanding), FETCH_DISCARD (outstanding request whose data is dropped).
REQ-019 FETCH_IDLE -> FETCH_WAIT: !halted && !redirect_valid && (count + 0) < DEPTH; imem_req asserted with imem_addr = fetch_pc in the same cycle the condition holds.
REQ-020 FETCH_WAIT with imem_ack: {fetch_pc, imem_rdata} pushed at clock edge; fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
REQ-021 After ack, if space remains (count after push/pop < DEPTH) and !halted, stay in FETCH_WAIT with imem_req high at the new fetch_pc next cycle (one instruction per cycle sustained); else FETCH_IDLE.
REQ-022 Space check counts the outstanding request: never issue when count == DEPTH; a request in flight always has a free slot on ack.
REQ-023 Simultaneous push and pop: count unchanged, both performed.
REQ-024 Earliest inst_valid: cycle after imem_ack.
REQ-025 redirect_valid has priority over every other event: FIFO flushed (count = 0, inst_valid low next cycle, pop ignored); fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-026 Redirect in FETCH_WAIT without ack in that cycle -> FETCH_DISCARD; imem_req stays high at the old address until imem_ack; that data dropped; then FETCH_IDLE rules issue redirect_pc.
REQ-027 Redirect in the same cycle as imem_ack: returning data dropped, no FETCH_DISCARD; redirect_pc issued next cycle.
REQ-028 Redirect during FETCH_DISCARD: fetch_pc updated to latest redirect_pc; discard continues.
REQ-029 halted: no new request issued; outstanding request completes and is pushed; FIFO contents and pops unaffected.

Reset
REQ-030 While rst_b low at a posedge: state FETCH_IDLE, count 0, fetch_pc = RESET_PC, imem_req 0, inst_valid 0, inst 0, inst_addr 0, occupancy 0.
REQ-031 Reset mid-request abandons it; imem_req low the cycle after reset sampled; a late imem_ack is ignored.
REQ-032 First request (imem_addr = RESET_PC) in the first cycle rst_b is sampled high.

Structure
REQ-033 Package fetch_pkg holds the state enum, the fetch-entry struct {pc, inst}, INST_W = 32 and the default RESET_PC.
REQ-034 FIFO storage/pointers in sub-module fetch_fifo (push, pop, flush, count); state machine and fetch_pc in inst_fetch_buffer.

Verification
REQ-035 Reset release, imem_ack same-cycle, inst_ready=1 -> addrs 0x0,0x4,0x8 issued back-to-back; inst_valid from cycle 2 with matching inst_addr.
REQ-036 inst_ready=0, DEPTH=4 -> exactly 4 acks accepted, imem_req low, occupancy=4; single pop -> one new request to 0x10.
REQ-037 Redirect to 0x103 while request to 0x8 outstanding, ack 3 cycles later -> imem_req held at 0x8, data dropped, next request 0x100, FIFO empty until its ack.
REQ-038 Redirect coincident with ack and pop -> data dropped, count 0 next cycle, next imem_addr = redirect_pc.
REQ-039 halted asserted during outstanding request -> ack pushed, no further imem_req; redirect to 0xFFFF_FFFC then deassert halted -> fetches 0xFFFF_FFFC then 0x0.
REQ-040 rst_b low during FETCH_DISCARD -> imem_req 0 next cycle, stray ack ignored, restart at RESET_PC.
